// File: rtl/feedback_readback.sv
// FSMC readback path: snapshots four signed wheel speeds plus robot status and serves them as
// 16-bit words on MCU read cycles, shadowing the high half so 32-bit values are never torn.
module feedback_readback #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] ID_WORD     = 16'hA518
) (
  input  logic        clk0_i,
  input  logic        rst_i,
  input  logic [31:0] fb_v1_i,
  input  logic [31:0] fb_v2_i,
  input  logic [31:0] fb_v3_i,
  input  logic [31:0] fb_v4_i,
  input  logic        fb_valid_i,
  input  logic        infrared_i,
  input  logic        shoot_done_i,
  input  logic        ne_i,
  input  logic        noe_i,
  input  logic [3:0]  addr_i,
  output logic [15:0] data_out_o,
  output logic        data_oe_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ne_sync_q;
  logic [SYNC_STAGES-1:0] noe_sync_q;
  logic                   rd_d_q;
  logic                   rd_s;
  logic                   rd_rise_s;
  logic [3:0]             addr_q, addr_d;
  logic [15:0]            data_out_q, data_out_d;
  logic                   data_oe_q, data_oe_d;
  logic [31:0]            snap_q [4];
  logic [31:0]            fb_vec_s [4];
  logic [15:0]            hi_shadow_q [4];
  logic [15:0]            seq_cnt_q;
  logic                   shoot_sticky_q;
  logic                   infrared_q;
  logic                   shadow_we_s;
  logic                   sticky_clr_s;
  logic [15:0]            rd_mux_s;
  logic [1:0]             sel_s;

  assign fb_vec_s[0] = fb_v1_i;
  assign fb_vec_s[1] = fb_v2_i;
  assign fb_vec_s[2] = fb_v3_i;
  assign fb_vec_s[3] = fb_v4_i;

  assign sel_s     = addr_q[2:1];
  assign rd_s      = ~ne_sync_q[SYNC_STAGES-1] & ~noe_sync_q[SYNC_STAGES-1];
  assign rd_rise_s = rd_s & ~rd_d_q;

  // Bus control synchronizers; reset to the idle (deasserted-high) level.
  always_ff @(posedge clk0_i or posedge rst_i) begin
    if (rst_i) begin
      ne_sync_q  <= {SYNC_STAGES{1'b1}};
      noe_sync_q <= {SYNC_STAGES{1'b1}};
      rd_d_q     <= 1'b0;
    end else begin
      ne_sync_q  <= {ne_sync_q[SYNC_STAGES-2:0], ne_i};
      noe_sync_q <= {noe_sync_q[SYNC_STAGES-2:0], noe_i};
      rd_d_q     <= rd_s;
    end
  end

  // Speed snapshot and sample sequence counter.
  always_ff @(posedge clk0_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 4; k++) begin
        snap_q[k] <= 32'h0000_0000;
      end
      seq_cnt_q <= 16'h0000;
    end else if (fb_valid_i) begin
      for (int k = 0; k < 4; k++) begin
        snap_q[k] <= fb_vec_s[k];
      end
      seq_cnt_q <= seq_cnt_q + 16'h0001;
    end else begin
      seq_cnt_q <= seq_cnt_q;
    end
  end

  // High-half shadow, loaded from the pre-update snapshot whenever a low half is served.
  always_ff @(posedge clk0_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 4; k++) begin
        hi_shadow_q[k] <= 16'h0000;
      end
    end else if (shadow_we_s) begin
      hi_shadow_q[sel_s] <= snap_q[sel_s][31:16];
    end else begin
      hi_shadow_q[sel_s] <= hi_shadow_q[sel_s];
    end
  end

  // Status bits: a new kick takes priority over the clear from a completed status read.
  always_ff @(posedge clk0_i or posedge rst_i) begin
    if (rst_i) begin
      shoot_sticky_q <= 1'b0;
      infrared_q     <= 1'b0;
    end else begin
      infrared_q <= infrared_i;
      if (shoot_done_i) begin
        shoot_sticky_q <= 1'b1;
      end else if (sticky_clr_s) begin
        shoot_sticky_q <= 1'b0;
      end else begin
        shoot_sticky_q <= shoot_sticky_q;
      end
    end
  end

  // Word address decode of the readable register map.
  always_comb begin
    rd_mux_s = 16'h0000;
    if (addr_q[3] == 1'b0) begin
      if (addr_q[0] == 1'b0) begin
        rd_mux_s = snap_q[sel_s][15:0];
      end else begin
        rd_mux_s = hi_shadow_q[sel_s];
      end
    end else begin
      case (addr_q)
        4'd8:    rd_mux_s = {14'b0, shoot_sticky_q, infrared_q};
        4'd9:    rd_mux_s = seq_cnt_q;
        4'd15:   rd_mux_s = ID_WORD;
        default: rd_mux_s = 16'h0000;
      endcase
    end
  end

  // Read-cycle FSM state and registered pad outputs.
  always_ff @(posedge clk0_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= 4'd0;
      data_out_q <= 16'h0000;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
    end
  end

  // Next-state logic; SETUP always advances so a truncated read cannot stall the FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_out_d   = data_out_q;
    data_oe_d    = data_oe_q;
    shadow_we_s  = 1'b0;
    sticky_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        data_oe_d = 1'b0;
        if (rd_rise_s) begin
          state_d = ST_SETUP;
          addr_d  = addr_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        data_out_d  = rd_mux_s;
        data_oe_d   = 1'b1;
        state_d     = ST_DRIVE;
        shadow_we_s = ~addr_q[3] & ~addr_q[0];
      end
      ST_DRIVE: begin
        if (!rd_s) begin
          state_d      = ST_IDLE;
          data_oe_d    = 1'b0;
          sticky_clr_s = (addr_q == 4'd8);
        end else begin
          state_d   = ST_DRIVE;
          data_oe_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        data_oe_d = 1'b0;
      end
    endcase
  end

  assign data_out_o = data_out_q;
  assign data_oe_o  = data_oe_q;

endmodule

// File: tb/tb_feedback_readback.sv
// Randomized self-checking bench for feedback_readback against a word-level register-map model.
module tb_feedback_readback;

  logic        clk0 = 1'b0;
  logic        rst;
  logic [31:0] fb_v1, fb_v2, fb_v3, fb_v4;
  logic        fb_valid, infrared, shoot_done, ne, noe;
  logic [3:0]  addr;
  logic [15:0] data_out;
  logic        data_oe;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_snap [4];
  logic [15:0] m_shadow [4];
  logic [15:0] m_seq;
  logic        m_sticky;
  logic        m_ir;

  feedback_readback dut (
    .clk0_i(clk0), .rst_i(rst),
    .fb_v1_i(fb_v1), .fb_v2_i(fb_v2), .fb_v3_i(fb_v3), .fb_v4_i(fb_v4),
    .fb_valid_i(fb_valid), .infrared_i(infrared), .shoot_done_i(shoot_done),
    .ne_i(ne), .noe_i(noe), .addr_i(addr),
    .data_out_o(data_out), .data_oe_o(data_oe)
  );

  always #5 clk0 = ~clk0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_snap[k]   = 32'h0;
      m_shadow[k] = 16'h0;
    end
    m_seq    = 16'h0;
    m_sticky = 1'b0;
    m_ir     = 1'b0;
  endtask

  task automatic model_sample(input logic [31:0] a, b, c, d);
    m_snap[0] = a; m_snap[1] = b; m_snap[2] = c; m_snap[3] = d;
    m_seq     = m_seq + 16'd1;
  endtask

  // Word the MCU should see; a low-half read also refreshes the shadow of that wheel.
  task automatic model_read(input logic [3:0] a, output logic [15:0] w);
    int k;
    k = int'(a) / 2;
    if (a < 4'd8) begin
      if (a % 2 == 0) begin
        w = m_snap[k][15:0];
        m_shadow[k] = m_snap[k][31:16];
      end else begin
        w = m_shadow[k];
      end
    end else if (a == 4'd8) begin
      w = {14'b0, m_sticky, m_ir};
    end else if (a == 4'd9) begin
      w = m_seq;
    end else if (a == 4'd15) begin
      w = 16'hA518;
    end else begin
      w = 16'h0000;
    end
  endtask

  task automatic fb_sample(input logic [31:0] a, b, c, d);
    @(negedge clk0);
    fb_v1 = a; fb_v2 = b; fb_v3 = c; fb_v4 = d;
    fb_valid = 1'b1;
    @(negedge clk0);
    fb_valid = 1'b0;
    model_sample(a, b, c, d);
  endtask

  task automatic shoot_pulse();
    @(negedge clk0);
    shoot_done = 1'b1;
    @(negedge clk0);
    shoot_done = 1'b0;
    m_sticky = 1'b1;
  endtask

  task automatic set_ir(input logic v);
    @(negedge clk0);
    infrared = v;
    @(negedge clk0);
    m_ir = v;
  endtask

  // One full bus read; optionally lands a new sample on the SETUP edge or a kick on the clearing edge.
  task automatic bus_read(input logic [3:0] a, input bit tear, input logic [31:0] tv,
                          input bit kick_at_end, output logic [15:0] got);
    logic [15:0] exp;
    int lat;
    model_read(a, exp);
    @(negedge clk0);
    ne = 1'b0; addr = a; noe = 1'b0;
    lat = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk0);
      if (tear && cyc == 3) begin
        fb_v1 = tv; fb_v2 = tv; fb_v3 = tv; fb_v4 = tv;
        fb_valid = 1'b1;
      end
      if (cyc == 4) fb_valid = 1'b0;
      if (data_oe === 1'b1) begin
        lat = cyc;
        break;
      end
    end
    fb_valid = 1'b0;
    if (tear) model_sample(tv, tv, tv, tv);
    check_eq($sformatf("rd_lat a%0d", a), lat, 4);
    got = data_out;
    check_eq($sformatf("rd_data a%0d", a), data_out, exp);
    @(negedge clk0);
    check_eq("oe_hold", data_oe, 1'b1);
    noe = 1'b1; ne = 1'b1;
    lat = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk0);
      if (kick_at_end && cyc == 2) shoot_done = 1'b1;
      if (cyc == 3) shoot_done = 1'b0;
      if (data_oe === 1'b0) begin
        lat = cyc;
        break;
      end
    end
    shoot_done = 1'b0;
    if (a == 4'd8) m_sticky = kick_at_end;
    else if (kick_at_end) m_sticky = 1'b1;
    check_eq("oe_fall_lat", lat, 3);
    check_eq("data_keep", data_out, exp);
  endtask

  logic [15:0] w;

  initial begin
    rst = 1'b1; ne = 1'b1; noe = 1'b1; addr = 4'd0;
    fb_v1 = 32'h0; fb_v2 = 32'h0; fb_v3 = 32'h0; fb_v4 = 32'h0;
    fb_valid = 1'b0; infrared = 1'b0; shoot_done = 1'b0;
    model_reset();
    repeat (3) @(negedge clk0);
    check_eq("rst_oe", data_oe, 1'b0);
    check_eq("rst_data", data_out, 16'h0000);
    rst = 1'b0;

    // T1: reset in the middle of a driven read
    fb_sample(32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888);
    @(negedge clk0);
    ne = 1'b0; noe = 1'b0; addr = 4'd15;
    repeat (5) @(negedge clk0);
    check_eq("t1_oe_before_rst", data_oe, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("t1_oe_async_drop", data_oe, 1'b0);
    ne = 1'b1; noe = 1'b1;
    @(negedge clk0);
    rst = 1'b0;
    model_reset();
    bus_read(4'd15, 1'b0, 32'h0, 1'b0, w);
    bus_read(4'd9, 1'b0, 32'h0, 1'b0, w);
    bus_read(4'd1, 1'b0, 32'h0, 1'b0, w);

    // T4: sequence counter wraps after 65536 samples
    @(negedge clk0);
    fb_v1 = 32'hDEAD_BEEF; fb_v2 = 32'h0; fb_v3 = 32'h0; fb_v4 = 32'h8000_0001;
    fb_valid = 1'b1;
    repeat (65536) @(negedge clk0);
    fb_valid = 1'b0;
    for (int n = 0; n < 65536; n++) model_sample(32'hDEAD_BEEF, 32'h0, 32'h0, 32'h8000_0001);
    bus_read(4'd9, 1'b0, 32'h0, 1'b0, w);
    check_eq("t4_wrap_zero", w, 16'h0000);
    fb_sample(32'hDEAD_BEEF, 32'h0, 32'h0, 32'h8000_0001);
    bus_read(4'd9, 1'b0, 32'h0, 1'b0, w);
    check_eq("t4_wrap_one", w, 16'h0001);

    // T2: 32-bit read of wheel 2
    fb_sample(32'h0, 32'hFFFE_1234, 32'h0, 32'h0);
    bus_read(4'd2, 1'b0, 32'h0, 1'b0, w);
    check_eq("t2_lo", w, 16'h1234);
    bus_read(4'd3, 1'b0, 32'h0, 1'b0, w);
    check_eq("t2_hi", w, 16'hFFFE);

    // T3: high half comes from the shadow, not the live snapshot
    fb_sample(32'h0001_FFFF, 32'h0, 32'h0, 32'h0);
    bus_read(4'd0, 1'b0, 32'h0, 1'b0, w);
    check_eq("t3_lo_old", w, 16'hFFFF);
    fb_sample(32'h0002_0000, 32'h0, 32'h0, 32'h0);
    bus_read(4'd1, 1'b0, 32'h0, 1'b0, w);
    check_eq("t3_hi_shadow", w, 16'h0001);
    bus_read(4'd0, 1'b0, 32'h0, 1'b0, w);
    check_eq("t3_lo_new", w, 16'h0000);
    bus_read(4'd1, 1'b0, 32'h0, 1'b0, w);
    check_eq("t3_hi_new", w, 16'h0002);
    // sample coincident with low-half SETUP: both halves keep the old value
    bus_read(4'd6, 1'b1, 32'hABCD_5678, 1'b0, w);
    check_eq("t3_tear_lo", w, 16'h0000);
    bus_read(4'd7, 1'b0, 32'h0, 1'b0, w);
    check_eq("t3_tear_hi", w, 16'h0000);
    bus_read(4'd6, 1'b0, 32'h0, 1'b0, w);
    check_eq("t3_tear_lo_next", w, 16'h5678);

    // T5: shoot sticky and infrared status
    set_ir(1'b1);
    shoot_pulse();
    bus_read(4'd8, 1'b0, 32'h0, 1'b0, w);
    check_eq("t5_status_set", w, 16'h0003);
    bus_read(4'd8, 1'b0, 32'h0, 1'b1, w);
    check_eq("t5_status_clr", w, 16'h0001);
    bus_read(4'd8, 1'b0, 32'h0, 1'b0, w);
    check_eq("t5_set_wins", w, 16'h0003);

    // T6: write cycles ignored, short read glitch recovers
    @(negedge clk0);
    ne = 1'b0; noe = 1'b1; addr = 4'd10;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk0);
      check_eq("t6_write_oe", data_oe, 1'b0);
    end
    noe = 1'b0;
    repeat (2) @(negedge clk0);
    noe = 1'b1;
    repeat (10) @(negedge clk0);
    check_eq("t6_glitch_oe", data_oe, 1'b0);
    ne = 1'b1;
    bus_read(4'd15, 1'b0, 32'h0, 1'b0, w);

    // randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: fb_sample($urandom, $urandom, $urandom, $urandom);
        1: set_ir(1'($urandom_range(0, 1)));
        2: shoot_pulse();
        default: begin
          logic [3:0] ra;
          ra = 4'($urandom_range(0, 15));
          bus_read(ra, (ra < 4'd8) && (ra[0] == 1'b0) && ($urandom_range(0, 1) == 1),
                   $urandom, 1'($urandom_range(0, 3) == 0), w);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
